fetch_decode: RTL and testbench

Instruction fetch and decode stage of the 8-bit processor, directly upstream of the register file. It holds the program counter, fetches 16-bit instructions from instruction memory over a req/ack handshake, and decodes them into the register-file controls: read addresses, write address, `regwrite`, `memtoreg`, immediate. Decoded fields are held stable while the downstream stage stalls. Downstream can redirect the PC for a taken branch.

---
 rtl/fetch_decode.sv | 207 ++++++++++++++++++++
 tb/tb_fetch_decode.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode.sv
// Fetch/decode stage: PC, imem req/ack fetch, decode into register-file controls.
// Optional macro FD_ILLEGAL_TRAP_EN: undefined opcodes halt the stage and raise illegal.
module fetch_decode #(
  parameter int unsigned       PC_W     = 8,
  parameter logic [PC_W-1:0]   RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  input  logic              stall,
  input  logic              branch_en,
  input  logic [PC_W-1:0]   branch_target,
  output logic              dec_valid,
  output logic [PC_W-1:0]   pc,
  output logic [2:0]        ra1,
  output logic [2:0]        ra2,
  output logic [7:0]        wa,
  output logic              regwrite,
  output logic              memtoreg,
  output logic              memwrite,
  output logic              branch,
  output logic [2:0]        aluop,
  output logic [7:0]        imm,
  output logic              illegal
);

`ifdef FD_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_HALTED
  } state_e;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ALU  = 4'd1,
    OP_ADDI = 4'd2,
    OP_LD   = 4'd3,
    OP_ST   = 4'd4,
    OP_BEQ  = 4'd5,
    OP_JMP  = 4'd6,
    OP_HALT = 4'd15
  } op_e;

  state_e          state_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] dec_pc_q;
  logic            req_q;
  logic            dec_valid_q;
  logic [2:0]      ra1_q;
  logic [2:0]      ra2_q;
  logic [2:0]      rd_q;
  logic            regwrite_q;
  logic            memtoreg_q;
  logic            memwrite_q;
  logic            branch_q;
  logic [2:0]      aluop_q;
  logic [7:0]      imm_q;
  logic            halt_q;
  logic            illegal_q;

  logic [3:0]      op_d;
  logic            regwrite_d;
  logic            memtoreg_d;
  logic            memwrite_d;
  logic            branch_d;
  logic            halt_d;
  logic            jmp_d;
  logic            known_op_d;
  logic [2:0]      aluop_d;
  logic [7:0]      imm_d;
  logic [PC_W-1:0] pc_inc_d;

  always_comb begin
    op_d       = imem_rdata[15:12];
    regwrite_d = 1'b0;
    memtoreg_d = 1'b0;
    memwrite_d = 1'b0;
    branch_d   = 1'b0;
    halt_d     = 1'b0;
    jmp_d      = 1'b0;
    known_op_d = 1'b1;
    aluop_d    = 3'b000;
    imm_d      = {{2{imem_rdata[5]}}, imem_rdata[5:0]};
    pc_inc_d   = pc_q + PC_W'(1);
    case (op_d)
      OP_NOP:  ;
      OP_ALU: begin
        regwrite_d = 1'b1;
        aluop_d    = imem_rdata[2:0];
      end
      OP_ADDI: regwrite_d = 1'b1;
      OP_LD: begin
        regwrite_d = 1'b1;
        memtoreg_d = 1'b1;
      end
      OP_ST:   memwrite_d = 1'b1;
      OP_BEQ:  branch_d   = 1'b1;
      OP_JMP:  jmp_d      = 1'b1;
      OP_HALT: halt_d     = 1'b1;
      default: known_op_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      dec_pc_q    <= RESET_PC;
      req_q       <= 1'b0;
      dec_valid_q <= 1'b0;
      ra1_q       <= '0;
      ra2_q       <= '0;
      rd_q        <= '0;
      regwrite_q  <= 1'b0;
      memtoreg_q  <= 1'b0;
      memwrite_q  <= 1'b0;
      branch_q    <= 1'b0;
      aluop_q     <= '0;
      imm_q       <= '0;
      halt_q      <= 1'b0;
      illegal_q   <= 1'b0;
    end else if (branch_en) begin
      // Redirect wins over stall, halt and any ack arriving this cycle.
      state_q     <= S_FETCH;
      pc_q        <= branch_target;
      req_q       <= 1'b1;
      dec_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q <= S_FETCH;
          req_q   <= 1'b1;
        end
        S_FETCH: begin
          if (imem_ack) begin
            if (jmp_d) begin
              pc_q <= PC_W'(imem_rdata[7:0]);
            end else if (TRAP_EN && !known_op_d) begin
              state_q   <= S_HALTED;
              req_q     <= 1'b0;
              illegal_q <= 1'b1;
            end else begin
              state_q     <= S_DECODE;
              req_q       <= 1'b0;
              dec_valid_q <= 1'b1;
              dec_pc_q    <= pc_q;
              ra1_q       <= imem_rdata[8:6];
              ra2_q       <= imem_rdata[5:3];
              rd_q        <= imem_rdata[11:9];
              regwrite_q  <= regwrite_d;
              memtoreg_q  <= memtoreg_d;
              memwrite_q  <= memwrite_d;
              branch_q    <= branch_d;
              aluop_q     <= aluop_d;
              imm_q       <= imm_d;
              halt_q      <= halt_d;
            end
          end
        end
        S_DECODE: begin
          if (!stall) begin
            dec_valid_q <= 1'b0;
            if (halt_q) begin
              state_q <= S_HALTED;
            end else begin
              state_q <= S_FETCH;
              pc_q    <= pc_inc_d;
              req_q   <= 1'b1;
            end
          end
        end
        S_HALTED: ;
        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign dec_valid = dec_valid_q;
  assign pc        = dec_pc_q;
  assign ra1       = ra1_q;
  assign ra2       = ra2_q;
  assign wa        = {5'b0, rd_q};
  assign regwrite  = regwrite_q;
  assign memtoreg  = memtoreg_q;
  assign memwrite  = memwrite_q;
  assign branch    = branch_q;
  assign aluop     = aluop_q;
  assign imm       = imm_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_fetch_decode.sv
// Directed self-checking bench for fetch_decode with a zero-wait instruction memory model.
module tb_fetch_decode;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        stall;
  logic        branch_en;
  logic [7:0]  branch_target;
  logic        dec_valid;
  logic [7:0]  pc;
  logic [2:0]  ra1, ra2, aluop;
  logic [7:0]  wa, imm;
  logic        regwrite, memtoreg, memwrite, branch, illegal;

  logic [15:0] mem [256];
  bit          auto_ack;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  fetch_decode #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .branch_en(branch_en), .branch_target(branch_target),
    .dec_valid(dec_valid), .pc(pc), .ra1(ra1), .ra2(ra2), .wa(wa),
    .regwrite(regwrite), .memtoreg(memtoreg), .memwrite(memwrite), .branch(branch),
    .aluop(aluop), .imm(imm), .illegal(illegal)
  );

  // {req, addr, dec_valid, pc, ra1, ra2, wa, regwrite, memtoreg, memwrite, branch, aluop, imm, illegal}
  function automatic logic [47:0] snap();
    return {imem_req, imem_addr, dec_valid, pc, ra1, ra2, wa,
            regwrite, memtoreg, memwrite, branch, aluop, imm, illegal};
  endfunction

  task automatic drive_mem();
    imem_ack   = auto_ack & imem_req;
    imem_rdata = mem[imem_addr];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive_mem();
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    stall = 1'b0;
    branch_en = 1'b0;
    branch_target = 8'h00;
    auto_ack = 1'b0;
    imem_ack = 1'b0;
    imem_rdata = 16'h0000;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; branch_en = 1'b0; branch_target = 8'h00;
    imem_ack = 1'b0; imem_rdata = 16'h0000; auto_ack = 1'b0;
    #1;
    n_cmp++; if (snap() !== 48'h0) begin n_err++; $display("FAIL reset_outputs: got %h want %h", snap(), 48'h0); end
    @(negedge clk); rst_n = 1'b1;
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL idle_req: got %b want 0", imem_req); end
    step();
    n_cmp++; if ({imem_req, imem_addr} !== {1'b1, 8'h00}) begin n_err++; $display("FAIL first_req: got %b/%h want 1/00", imem_req, imem_addr); end
    step();
    n_cmp++; if ({imem_req, imem_addr} !== {1'b1, 8'h00}) begin n_err++; $display("FAIL req_held: got %b/%h want 1/00", imem_req, imem_addr); end
    // Reset mid-fetch; an ack arriving in IDLE afterwards must be ignored.
    #3 rst_n = 1'b0; imem_ack = 1'b1; imem_rdata = 16'h1A5B;
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL async_reset_req: got %b want 0", imem_req); end
    @(negedge clk); rst_n = 1'b1;
    step();
    n_cmp++; if ({imem_req, dec_valid, regwrite} !== 3'b100) begin n_err++; $display("FAIL ack_in_idle_ignored: got %b want 100", {imem_req, dec_valid, regwrite}); end
  endtask

  task automatic test_alu();
    reset_dut();
    mem[0] = 16'h1A5B; auto_ack = 1'b1; stall = 1'b1;
    step(); step();
    n_cmp++; if (snap() !== {1'b0, 8'h00, 1'b1, 8'h00, 3'd1, 3'd3, 8'h05, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 8'h1B, 1'b0})
      begin n_err++; $display("FAIL alu_decode: got %h", snap()); end
  endtask

  task automatic test_stall_ld();
    reset_dut();
    mem[0] = 16'h3C7E; auto_ack = 1'b1; stall = 1'b1;
    step(); step();
    for (int c = 0; c < 4; c++) begin
      n_cmp++; if (snap() !== {1'b0, 8'h00, 1'b1, 8'h00, 3'd1, 3'd7, 8'h06, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'hFE, 1'b0})
        begin n_err++; $display("FAIL ld_stall_hold[%0d]: got %h", c, snap()); end
      step();
    end
    stall = 1'b0;
    step();
    n_cmp++; if ({imem_req, imem_addr, dec_valid, pc} !== {1'b1, 8'h01, 1'b0, 8'h00}) begin n_err++; $display("FAIL ld_next_fetch: got %h want 1_01_0_00", {imem_req, imem_addr, dec_valid, pc}); end
  endtask

  task automatic test_branch();
    reset_dut();
    mem[0] = 16'h1A5B; mem[8'h40] = 16'h2A3F; auto_ack = 1'b1; stall = 1'b1;
    step();
    branch_en = 1'b1; branch_target = 8'h40;
    step();
    branch_en = 1'b0;
    n_cmp++; if ({imem_req, imem_addr, dec_valid, regwrite, ra1} !== {1'b1, 8'h40, 1'b0, 1'b0, 3'd0}) begin n_err++; $display("FAIL branch_discard: got %h", {imem_req, imem_addr, dec_valid, regwrite, ra1}); end
    step();
    n_cmp++; if (snap() !== {1'b0, 8'h40, 1'b1, 8'h40, 3'd0, 3'd7, 8'h05, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'hFF, 1'b0})
      begin n_err++; $display("FAIL branch_target_decode: got %h", snap()); end
    // Redirect from a stalled DECODE overrides the stall.
    branch_en = 1'b1; branch_target = 8'h00;
    step();
    branch_en = 1'b0;
    n_cmp++; if ({imem_req, imem_addr, dec_valid} !== {1'b1, 8'h00, 1'b0}) begin n_err++; $display("FAIL branch_over_stall: got %h want 1_00_0", {imem_req, imem_addr, dec_valid}); end
  endtask

  task automatic test_wrap();
    reset_dut();
    mem[8'hFF] = 16'h60F0; auto_ack = 1'b1; stall = 1'b1;
    branch_en = 1'b1; branch_target = 8'hFF;
    step();
    branch_en = 1'b0;
    step();
    n_cmp++; if ({imem_req, imem_addr, dec_valid} !== {1'b1, 8'hF0, 1'b0}) begin n_err++; $display("FAIL jmp_target: got %h want 1_f0_0", {imem_req, imem_addr, dec_valid}); end
    step();
    n_cmp++; if ({dec_valid, pc} !== {1'b1, 8'hF0}) begin n_err++; $display("FAIL jmp_decode_pc: got %h want 1_f0", {dec_valid, pc}); end

    reset_dut();
    auto_ack = 1'b1;
    branch_en = 1'b1; branch_target = 8'hFF;
    step();
    branch_en = 1'b0;
    step();
    n_cmp++; if ({dec_valid, pc} !== {1'b1, 8'hFF}) begin n_err++; $display("FAIL nop_ff_decode: got %h want 1_ff", {dec_valid, pc}); end
    step();
    n_cmp++; if ({imem_req, imem_addr} !== {1'b1, 8'h00}) begin n_err++; $display("FAIL pc_wrap: got %h want 1_00", {imem_req, imem_addr}); end
  endtask

  task automatic test_illegal();
    reset_dut();
    mem[0] = 16'h7000; auto_ack = 1'b1;
    step(); step();
`ifdef FD_ILLEGAL_TRAP_EN
    n_cmp++; if ({illegal, dec_valid, imem_req} !== 3'b100) begin n_err++; $display("FAIL illegal_trap: got %b want 100", {illegal, dec_valid, imem_req}); end
    step(); step();
    n_cmp++; if ({illegal, imem_req} !== 2'b10) begin n_err++; $display("FAIL illegal_stays: got %b want 10", {illegal, imem_req}); end
`else
    n_cmp++; if ({illegal, dec_valid, regwrite, memtoreg, memwrite, branch} !== 6'b010000) begin n_err++; $display("FAIL illegal_as_nop: got %b want 010000", {illegal, dec_valid, regwrite, memtoreg, memwrite, branch}); end
    step();
    n_cmp++; if ({imem_req, imem_addr} !== {1'b1, 8'h01}) begin n_err++; $display("FAIL illegal_fetch_continues: got %h want 1_01", {imem_req, imem_addr}); end
`endif
  endtask

  task automatic test_back_to_back();
    reset_dut();
    mem[0] = 16'h1A5B; mem[1] = 16'h3C7E; mem[2] = 16'h2A3F; auto_ack = 1'b1;
    step(); step();
    n_cmp++; if ({dec_valid, pc, aluop} !== {1'b1, 8'h00, 3'd3}) begin n_err++; $display("FAIL b2b_0: got %h", {dec_valid, pc, aluop}); end
    step(); step();
    n_cmp++; if ({dec_valid, pc, memtoreg, imm} !== {1'b1, 8'h01, 1'b1, 8'hFE}) begin n_err++; $display("FAIL b2b_1: got %h", {dec_valid, pc, memtoreg, imm}); end
    step(); step();
    n_cmp++; if ({dec_valid, pc, memtoreg, imm} !== {1'b1, 8'h02, 1'b0, 8'hFF}) begin n_err++; $display("FAIL b2b_2: got %h", {dec_valid, pc, memtoreg, imm}); end
  endtask

  task automatic test_halt_reset();
    reset_dut();
    mem[0] = 16'h3C7E; mem[1] = 16'hF000; auto_ack = 1'b1;
    step(); step(); step();
    stall = 1'b1;
    step();
    for (int c = 0; c < 2; c++) begin
      n_cmp++; if (snap() !== {1'b0, 8'h01, 1'b1, 8'h01, 3'd0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0})
        begin n_err++; $display("FAIL halt_stall_hold[%0d]: got %h", c, snap()); end
      step();
    end
    #3 rst_n = 1'b0;
    #1;
    n_cmp++; if (snap() !== 48'h0) begin n_err++; $display("FAIL reset_mid_stall: got %h want 0", snap()); end
    stall = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    step();
    n_cmp++; if ({imem_req, imem_addr} !== {1'b1, 8'h00}) begin n_err++; $display("FAIL restart_fetch: got %h want 1_00", {imem_req, imem_addr}); end
  endtask

  task automatic test_halted();
    reset_dut();
    mem[0] = 16'hF000; auto_ack = 1'b1;
    step(); step(); step();
    n_cmp++; if ({imem_req, dec_valid} !== 2'b00) begin n_err++; $display("FAIL halted_enter: got %b want 00", {imem_req, dec_valid}); end
    step(); step();
    n_cmp++; if ({imem_req, dec_valid, imem_addr} !== {2'b00, 8'h00}) begin n_err++; $display("FAIL halted_stays: got %h want 0_00", {imem_req, dec_valid, imem_addr}); end
    branch_en = 1'b1; branch_target = 8'h10;
    step();
    branch_en = 1'b0;
    n_cmp++; if ({imem_req, imem_addr} !== {1'b1, 8'h10}) begin n_err++; $display("FAIL halted_exit_branch: got %h want 1_10", {imem_req, imem_addr}); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_stall_ld();
    test_branch();
    test_wrap();
    test_illegal();
    test_back_to_back();
    test_halt_reset();
    test_halted();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
